// File: rtl/reg_seq_pkg.sv
// Shared definitions for the register sequencer: command op-codes, FSM states
// and bit positions inside the registered strobe vector.
package reg_seq_pkg;

    localparam int OP_W = 3;

    localparam logic [OP_W-1:0] OP_NOP  = 3'd0;
    localparam logic [OP_W-1:0] OP_CLR  = 3'd1;
    localparam logic [OP_W-1:0] OP_LOAD = 3'd2;
    localparam logic [OP_W-1:0] OP_INC  = 3'd3;
    localparam logic [OP_W-1:0] OP_DEC  = 3'd4;
    localparam logic [OP_W-1:0] OP_SHR  = 3'd5;
    localparam logic [OP_W-1:0] OP_SHL  = 3'd6;
    localparam logic [OP_W-1:0] OP_ALU  = 3'd7;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    localparam int STB_CL  = 0;
    localparam int STB_LD  = 1;
    localparam int STB_INC = 2;
    localparam int STB_DEC = 3;
    localparam int STB_SR  = 4;
    localparam int STB_SL  = 5;
    localparam int STB_W   = 6;

    // Ops that honour cmd_cnt; all others run exactly one strobe cycle.
    function automatic logic is_repeat_op(input logic [OP_W-1:0] op);
        return (op == OP_INC) || (op == OP_DEC) || (op == OP_SHR) || (op == OP_SHL);
    endfunction

endpackage

// File: rtl/reg_seq_strobe_dec.sv
// Registered decoder from the next FSM state and op to the one-hot strobe
// vector, so the register sees glitch-free strobes aligned with RUN cycles.
module reg_seq_strobe_dec
    import reg_seq_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  state_e           state_d,
    input  logic [OP_W-1:0]  op_d,
    input  logic             fill_d,
    output logic [STB_W-1:0] strobe_q,
    output logic             ir_q,
    output logic             il_q
);

    logic [STB_W-1:0] strobe_d;
    logic             ir_d;
    logic             il_d;

    always_comb begin
        strobe_d = '0;
        ir_d     = 1'b0;
        il_d     = 1'b0;
        if (state_d == S_RUN) begin
            case (op_d)
                OP_CLR:          strobe_d[STB_CL]  = 1'b1;
                OP_LOAD, OP_ALU: strobe_d[STB_LD]  = 1'b1;
                OP_INC:          strobe_d[STB_INC] = 1'b1;
                OP_DEC:          strobe_d[STB_DEC] = 1'b1;
                OP_SHR: begin
                    strobe_d[STB_SR] = 1'b1;
                    ir_d             = fill_d;
                end
                OP_SHL: begin
                    strobe_d[STB_SL] = 1'b1;
                    il_d             = fill_d;
                end
                default: strobe_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            strobe_q <= '0;
            ir_q     <= 1'b0;
            il_q     <= 1'b0;
        end else begin
            strobe_q <= strobe_d;
            ir_q     <= ir_d;
            il_q     <= il_d;
        end
    end

endmodule

// File: rtl/reg_sequencer.sv
// Command-driven initiator for a 4-bit register and its ALU: one command per
// valid/ready handshake, expanded into timed register strobes, then a done pulse.
module reg_sequencer
    import reg_seq_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int OC_W  = 3,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [OP_W-1:0]  cmd_op,
    input  logic [WIDTH-1:0] cmd_arg,
    input  logic [CNT_W-1:0] cmd_cnt,
    input  logic [OC_W-1:0]  cmd_oc,
    input  logic [WIDTH-1:0] reg_out,
    output logic             cl,
    output logic             ld,
    output logic             inc,
    output logic             dec,
    output logic             sr,
    output logic             sl,
    output logic             ir,
    output logic             il,
    output logic [WIDTH-1:0] reg_in,
    output logic [OC_W-1:0]  oc,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] f,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    state_e           state_q, state_d;
    logic [OP_W-1:0]  op_q, op_d;
    logic [WIDTH-1:0] arg_q, arg_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] reg_in_q, reg_in_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [OC_W-1:0]  oc_q, oc_d;
    logic             alu_run_q, alu_run_d;
    logic [STB_W-1:0] strobe;
    logic             accept;
    logic             run_d;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            op_q    <= OP_NOP;
            arg_q   <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            arg_q   <= arg_d;
            rem_q   <= rem_d;
        end
    end

    // Next-state logic; rem counts strobe cycles still to issue.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        arg_d   = arg_q;
        rem_d   = rem_q;
        accept  = cmd_valid && (state_q == S_IDLE);
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    op_d  = cmd_op;
                    arg_d = cmd_arg;
                    if (cmd_op == OP_NOP || (is_repeat_op(cmd_op) && cmd_cnt == '0)) begin
                        state_d = S_DONE;
                        rem_d   = '0;
                    end else begin
                        state_d = S_RUN;
                        rem_d   = is_repeat_op(cmd_op) ? cmd_cnt : CNT_W'(1);
                    end
                end
            end
            S_RUN: begin
                rem_d = rem_q - CNT_W'(1);
                if (rem_q <= CNT_W'(1)) begin
                    state_d = S_DONE;
                    rem_d   = '0;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Single-cycle LOAD/ALU operands are captured on entry to RUN; the
    // register does not move on that edge, so a_q equals reg_out during RUN.
    always_comb begin
        run_d     = (state_d == S_RUN);
        alu_run_d = run_d && (op_d == OP_ALU);
        reg_in_d  = (run_d && op_d == OP_LOAD) ? arg_d : '0;
        oc_d      = alu_run_d ? cmd_oc : '0;
        a_d       = alu_run_d ? reg_out : '0;
        b_d       = alu_run_d ? arg_d : '0;
        result_d  = (state_q == S_DONE) ? reg_out : result_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            reg_in_q  <= '0;
            oc_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            alu_run_q <= 1'b0;
            result_q  <= '0;
        end else begin
            reg_in_q  <= reg_in_d;
            oc_q      <= oc_d;
            a_q       <= a_d;
            b_q       <= b_d;
            alu_run_q <= alu_run_d;
            result_q  <= result_d;
        end
    end

    reg_seq_strobe_dec u_strobe_dec (
        .clk      (clk),
        .rst      (rst),
        .state_d  (state_d),
        .op_d     (op_d),
        .fill_d   (arg_d[0]),
        .strobe_q (strobe),
        .ir_q     (ir),
        .il_q     (il)
    );

    // Outputs
    always_comb begin
        cmd_ready = (state_q == S_IDLE);
        done      = (state_q == S_DONE);
        cl        = strobe[STB_CL];
        ld        = strobe[STB_LD];
        inc       = strobe[STB_INC];
        dec       = strobe[STB_DEC];
        sr        = strobe[STB_SR];
        sl        = strobe[STB_SL];
        reg_in    = alu_run_q ? f : reg_in_q;
        oc        = oc_q;
        a         = a_q;
        b         = b_q;
        result    = result_q;
    end

endmodule

// File: tb/tb_reg_sequencer.sv
// Bench for reg_sequencer with a behavioural 4-bit register and ALU; a scoreboard
// queue holds expected results, popped by a monitor on each done pulse.
module tb_reg_sequencer;
    import reg_seq_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [2:0] cmd_op = '0;
    logic [3:0] cmd_arg = '0;
    logic [2:0] cmd_cnt = '0;
    logic [2:0] cmd_oc = '0;
    logic [3:0] reg_q = '0;
    logic       cl, ld, inc, dec, sr, sl, ir, il, done;
    logic [3:0] reg_in, a, b, f, result;
    logic [2:0] oc;

    int checks = 0;
    int errors = 0;
    logic [3:0] exp_q[$];
    logic [3:0] alu_exp [8];

    int n_cl = 0, n_ld = 0, n_inc = 0, n_dec = 0, n_sr = 0, n_sl = 0;
    int n_ir = 0, n_il = 0, n_busy = 0, n_multi = 0, n_fillbad = 0;
    int s_cl, s_ld, s_inc, s_dec, s_sr, s_sl, s_ir, s_il, s_busy;

    reg_sequencer #(.WIDTH(4), .OC_W(3), .CNT_W(3)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_arg(cmd_arg), .cmd_cnt(cmd_cnt), .cmd_oc(cmd_oc),
        .reg_out(reg_q), .cl(cl), .ld(ld), .inc(inc), .dec(dec), .sr(sr), .sl(sl),
        .ir(ir), .il(il), .reg_in(reg_in), .oc(oc), .a(a), .b(b), .f(f),
        .done(done), .result(result)
    );

    always #5 clk = ~clk;

    // Behavioural register (no reset of its own) and ALU.
    always @(posedge clk) begin
        if (cl)       reg_q <= 4'b0000;
        else if (ld)  reg_q <= reg_in;
        else if (inc) reg_q <= reg_q + 4'd1;
        else if (dec) reg_q <= reg_q - 4'd1;
        else if (sr)  reg_q <= {ir, reg_q[3:1]};
        else if (sl)  reg_q <= {reg_q[2:0], il};
    end

    always_comb begin
        case (oc)
            3'd0: f = a + b;
            3'd1: f = a - b;
            3'd2: f = a & b;
            3'd3: f = a | b;
            3'd4: f = a ^ b;
            3'd5: f = ~a;
            3'd6: f = a;
            default: f = b;
        endcase
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Strobe activity counters, sampled mid-cycle.
    always @(negedge clk) begin
        if (!rst) begin
            n_cl  += int'(cl);
            n_ld  += int'(ld);
            n_inc += int'(inc);
            n_dec += int'(dec);
            n_sr  += int'(sr);
            n_sl  += int'(sl);
            n_ir  += int'(sr && ir);
            n_il  += int'(sl && il);
            if (!cmd_ready) n_busy++;
            if ($countones({cl, ld, inc, dec, sr, sl}) > 1) n_multi++;
            if ((ir && !sr) || (il && !sl)) n_fillbad++;
        end
    end

    // Scoreboard monitor: result is registered at the end of the done cycle.
    initial begin
        logic [3:0] e;
        forever begin
            @(negedge clk);
            if (done) begin
                @(negedge clk);
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("result", {28'd0, result}, {28'd0, e});
                end
            end
        end
    end

    task automatic snap();
        s_cl = n_cl; s_ld = n_ld; s_inc = n_inc; s_dec = n_dec; s_sr = n_sr;
        s_sl = n_sl; s_ir = n_ir; s_il = n_il; s_busy = n_busy;
    endtask

    task automatic issue(input logic [2:0] op, input logic [3:0] arg, input logic [2:0] cnt,
                         input logic [2:0] coc, input logic [3:0] exp, input bit push, input bit hold);
        int t = 0;
        @(negedge clk);
        while (!cmd_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!cmd_ready) check("ready_timeout", 32'd0, 32'd1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_arg   = arg;
        cmd_cnt   = cnt;
        cmd_oc    = coc;
        if (push) exp_q.push_back(exp);
        @(posedge clk);
        #1;
        if (hold) cmd_op = OP_CLR;
        else      cmd_valid = 1'b0;
    endtask

    task automatic wait_done();
        int t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!done && t < 100);
        if (!done) check("done_timeout", 32'd0, 32'd1);
        cmd_valid = 1'b0;
        @(negedge clk);
        #1;
    endtask

    task automatic run(input logic [2:0] op, input logic [3:0] arg, input logic [2:0] cnt,
                       input logic [3:0] exp);
        snap();
        issue(op, arg, cnt, 3'd0, exp, 1'b1, 1'b0);
        wait_done();
    endtask

    initial begin
        int done_seen;
        alu_exp = '{4'b1000, 4'b0010, 4'b0001, 4'b0111, 4'b0110, 4'b1010, 4'b0101, 4'b0011};
        #2 rst = 1'b1;
        #3 rst = 1'b0;
        @(negedge clk);
        check("reset_state",
              {3'd0, cmd_ready, cl, ld, inc, dec, sr, sl, ir, il, done, reg_in, oc, a, b, result},
              {3'd0, 1'b1, 28'd0});

        run(OP_LOAD, 4'b1010, 3'd0, 4'b1010);
        check("load_ld_cycles", n_ld - s_ld, 1);
        check("load_busy", n_busy - s_busy, 2);

        run(OP_LOAD, 4'b1110, 3'd0, 4'b1110);
        run(OP_INC, 4'b0000, 3'd3, 4'b0001);
        check("inc_cycles", n_inc - s_inc, 3);
        check("inc_busy", n_busy - s_busy, 4);

        run(OP_CLR, 4'b1111, 3'd5, 4'b0000);
        check("clr_cycles", n_cl - s_cl, 1);

        run(OP_LOAD, 4'b1001, 3'd0, 4'b1001);
        run(OP_SHR, 4'b0001, 3'd2, 4'b1110);
        check("shr_cycles", n_sr - s_sr, 2);
        check("shr_ir_cycles", n_ir - s_ir, 2);
        run(OP_SHL, 4'b1110, 3'd1, 4'b1100);
        check("shl_cycles", n_sl - s_sl, 1);
        check("shl_il_zero", n_il - s_il, 0);

        run(OP_INC, 4'b0000, 3'd0, 4'b1100);
        check("inc0_busy", n_busy - s_busy, 1);
        check("inc0_strobes", n_inc - s_inc, 0);
        run(OP_NOP, 4'b1111, 3'd7, 4'b1100);
        check("nop_busy", n_busy - s_busy, 1);
        check("nop_strobes", (n_ld - s_ld) + (n_cl - s_cl) + (n_inc - s_inc), 0);

        run(OP_LOAD, 4'b0001, 3'd0, 4'b0001);
        run(OP_DEC, 4'b0000, 3'd3, 4'b1110);
        check("dec_cycles", n_dec - s_dec, 3);

        // Reset during the third DEC strobe cycle.
        run(OP_LOAD, 4'b1000, 3'd0, 4'b1000);
        snap();
        issue(OP_DEC, 4'b0000, 3'd7, 3'd0, 4'b0000, 1'b0, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("rst_strobes_drop", {26'd0, cl, ld, inc, dec, sr, sl}, 32'd0);
        #1 rst = 1'b0;
        done_seen = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            done_seen += int'(done);
        end
        check("rst_no_done", done_seen, 0);
        check("rst_ready", {31'd0, cmd_ready}, 32'd1);
        check("rst_result", {28'd0, result}, 32'd0);
        check("rst_dec_cycles", n_dec - s_dec, 2);
        check("rst_reg_value", {28'd0, reg_q}, {28'd0, 4'b0110});

        for (int k = 0; k < 8; k++) begin
            run(OP_LOAD, 4'b0101, 3'd0, 4'b0101);
            snap();
            issue(OP_ALU, 4'b0011, 3'd6, 3'(k), alu_exp[k], 1'b1, (k == 3));
            wait_done();
            check("alu_busy", n_busy - s_busy, 2);
            check("alu_no_second_cmd", n_cl - s_cl, 0);
        end

        repeat (4) @(negedge clk);
        check("pending_results", exp_q.size(), 0);
        check("multi_strobe", n_multi, 0);
        check("fill_outside_shift", n_fillbad, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench still running at %0t", $time);
        $fatal(1);
    end

endmodule
